// File: rtl/mix_sched_pkg.sv
// Shared types and default parameters for the voice mix scheduler.
package mix_sched_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    WRITE   = 1'b1
  } state_t;

  localparam int DEF_NUM_VOICES     = 4;
  localparam int DEF_SAMPLE_W       = 32;
  localparam int DEF_GATHER_TIMEOUT = 64;

endpackage

// File: rtl/mix_sat.sv
// Saturating reduction of the wide mix accumulator to a signed SAMPLE_W sample.
// Instantiated by mix_scheduler only when MIX_SATURATE_EN is defined.
module mix_sat
  import mix_sched_pkg::*;
#(
  parameter int ACC_W    = DEF_SAMPLE_W + 2,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic [ACC_W-1:0]    acc,
  output logic [SAMPLE_W-1:0] sample,
  output logic                clip
);

  localparam int HEAD_W = ACC_W - SAMPLE_W + 1;

  // The value fits when every bit above the sample's sign bit repeats that sign bit.
  logic [HEAD_W-1:0] head;
  logic              in_range;

  assign head     = acc[ACC_W-1:SAMPLE_W-1];
  assign in_range = (head == '0) || (head == '1);

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    clip   = !in_range;
    sample = acc[SAMPLE_W-1:0];
    if (!in_range) begin
      if (acc[ACC_W-1]) sample = {1'b1, {(SAMPLE_W-1){1'b0}}};
      else              sample = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mix_scheduler.sv
// Round-robin gather of NUM_VOICES pad voices into one mixed frame sample for the codec.
// Optional build macro MIX_SATURATE_EN: clamp out-of-range sums and pulse clip (default: wrap).
module mix_scheduler
  import mix_sched_pkg::*;
#(
  parameter int NUM_VOICES     = DEF_NUM_VOICES,
  parameter int SAMPLE_W       = DEF_SAMPLE_W,
  parameter int GATHER_TIMEOUT = DEF_GATHER_TIMEOUT
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic [NUM_VOICES-1:0]        voice_active,
  input  logic [NUM_VOICES-1:0]        voice_valid,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
  output logic [NUM_VOICES-1:0]        voice_ready,
  input  logic                         audio_out_allowed,
  output logic [SAMPLE_W-1:0]          left_channel_audio_out,
  output logic [SAMPLE_W-1:0]          right_channel_audio_out,
  output logic                         write_audio_out,
  output logic                         underrun,
  output logic                         clip
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam int CNT_W = $clog2(GATHER_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(GATHER_TIMEOUT - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    wait_cnt;
  logic [SAMPLE_W-1:0] mix_out;

  logic [SAMPLE_W-1:0] cur_sample;
  logic                collecting;
  logic                cur_active;
  logic                handshake;
  logic                timed_out;
  logic                voice_done;
  logic [ACC_W-1:0]    addend;
  logic [ACC_W-1:0]    next_acc;
  logic [SAMPLE_W-1:0] red_sample;
  logic                red_clip;

  // Ready is decoded combinationally so a voice dropping active is skipped in the same cycle.
  always_comb begin
    cur_sample  = voice_data[idx*SAMPLE_W +: SAMPLE_W];
    collecting  = resetn && (state == COLLECT);
    cur_active  = voice_active[idx];
    handshake   = collecting && cur_active && voice_valid[idx];
    timed_out   = collecting && cur_active && !voice_valid[idx] && (wait_cnt == WAIT_MAX);
    voice_done  = !cur_active || handshake || timed_out;
    addend      = handshake ? {{IDX_W{cur_sample[SAMPLE_W-1]}}, cur_sample} : '0;
    next_acc    = acc + addend;
    voice_ready = '0;
    if (collecting && cur_active) voice_ready[idx] = 1'b1;
  end

`ifdef MIX_SATURATE_EN
  mix_sat #(
    .ACC_W    (ACC_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_sat (
    .acc    (next_acc),
    .sample (red_sample),
    .clip   (red_clip)
  );
`else
  assign red_sample = next_acc[SAMPLE_W-1:0];
  assign red_clip   = 1'b0;
`endif

  assign write_audio_out         = resetn && (state == WRITE) && audio_out_allowed;
  assign left_channel_audio_out  = mix_out;
  assign right_channel_audio_out = mix_out;

  // NOTE: state uses non-blocking assignments and clears asynchronously on resetn low.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= COLLECT;
      idx      <= '0;
      acc      <= '0;
      wait_cnt <= '0;
      mix_out  <= '0;
      underrun <= 1'b0;
      clip     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      clip     <= 1'b0;
      case (state)
        COLLECT: begin
          underrun <= timed_out;
          if (voice_done) begin
            wait_cnt <= '0;
            if (idx == LAST_IDX) begin
              state   <= WRITE;
              idx     <= '0;
              acc     <= '0;
              mix_out <= red_sample;
              clip    <= red_clip;
            end else begin
              idx <= idx + 1'b1;
              acc <= next_acc;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (audio_out_allowed) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_scheduler.sv
// Self-checking bench for mix_scheduler: a frame-level timing/sum model drives and checks every cycle.
module tb_mix_scheduler;

  localparam int NV = 4;
  localparam int SW = 32;
  localparam int TO = 64;

  logic               CLOCK_50 = 1'b0;
  logic               resetn   = 1'b0;
  logic [NV-1:0]      voice_active;
  logic [NV-1:0]      voice_valid;
  logic [NV*SW-1:0]   voice_data;
  logic [NV-1:0]      voice_ready;
  logic               audio_out_allowed;
  logic [SW-1:0]      left_out;
  logic [SW-1:0]      right_out;
  logic               write_audio_out;
  logic               underrun;
  logic               clip;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  mix_scheduler #(
    .NUM_VOICES     (NV),
    .SAMPLE_W       (SW),
    .GATHER_TIMEOUT (TO)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .resetn                  (resetn),
    .voice_active            (voice_active),
    .voice_valid             (voice_valid),
    .voice_data              (voice_data),
    .voice_ready             (voice_ready),
    .audio_out_allowed       (audio_out_allowed),
    .left_channel_audio_out  (left_out),
    .right_channel_audio_out (right_out),
    .write_audio_out         (write_audio_out),
    .underrun                (underrun),
    .clip                    (clip)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame description: activity, sample, cycle valid rises (-1 never), cycle offset active drops (-1 never).
  bit                   f_act [NV];
  logic signed [SW-1:0] f_smp [NV];
  int                   f_dly [NV];
  int                   f_drop[NV];
  int                   f_hold;
  logic [SW-1:0]        prev_out = '0;

  task automatic clear_frame();
    for (int j = 0; j < NV; j++) begin
      f_act[j]  = 1'b0;
      f_smp[j]  = '0;
      f_dly[j]  = -1;
      f_drop[j] = -1;
    end
    f_hold = 0;
  endtask

  function automatic logic [SW-1:0] reduce(input longint sum, output bit clp);
    longint mx;
    longint mn;
    mx  = (longint'(1) <<< (SW - 1)) - 1;
    mn  = -(longint'(1) <<< (SW - 1));
    clp = 1'b0;
`ifdef MIX_SATURATE_EN
    if (sum > mx) begin
      clp = 1'b1;
      return mx[SW-1:0];
    end
    if (sum < mn) begin
      clp = 1'b1;
      return mn[SW-1:0];
    end
`endif
    return sum[SW-1:0];
  endfunction

  // Plays one frame from COLLECT idx 0 through its write strobe, checking every cycle.
  task automatic run_frame(input string name, output int n_writes, output int n_underruns,
                           output logic [SW-1:0] written);
    int            start[NV+1];
    int            ur_at[NV];
    longint        sum;
    int            t;
    int            e;
    int            cj;
    bit            mclip;
    logic [SW-1:0] exp_out;
    logic [SW-1:0] exp_lr;
    logic [NV-1:0] exp_ready;
    bit            exp_wr;
    bit            exp_ur;
    bit            exp_clip;

    sum = 0;
    t   = 0;
    for (int j = 0; j < NV; j++) begin
      start[j] = t;
      ur_at[j] = -1;
      if (!f_act[j]) begin
        t = t + 1;
      end else if (f_dly[j] >= 0) begin
        t   = ((f_dly[j] > t) ? f_dly[j] : t) + 1;
        sum = sum + longint'(f_smp[j]);
      end else if (f_drop[j] >= 0) begin
        t = t + f_drop[j] + 1;
      end else begin
        t        = t + TO;
        ur_at[j] = t;
      end
    end
    start[NV] = t;
    e         = t;
    exp_out   = reduce(sum, mclip);

    n_writes    = 0;
    n_underruns = 0;
    written     = 'x;
    for (int k = 0; k <= e + f_hold; k++) begin
      @(negedge CLOCK_50);
      resetn = 1'b1;
      cj = -1;
      for (int j = 0; j < NV; j++) begin
        if (k >= start[j] && k < start[j+1]) cj = j;
        voice_active[j]          = f_act[j] && !(f_drop[j] >= 0 && k >= start[j] + f_drop[j]);
        voice_valid[j]           = (f_dly[j] >= 0) && (k >= f_dly[j]);
        voice_data[j*SW +: SW]   = f_smp[j];
      end
      if (k < e) audio_out_allowed = 1'($urandom_range(0, 1));
      else       audio_out_allowed = (k == e + f_hold);
      #1;

      exp_ready = '0;
      if (cj >= 0 && voice_active[cj]) exp_ready[cj] = 1'b1;
      exp_wr   = (k == e + f_hold);
      exp_ur   = 1'b0;
      for (int j = 0; j < NV; j++) if (ur_at[j] == k) exp_ur = 1'b1;
      exp_clip = (k == e) && mclip;
      exp_lr   = (k >= e) ? exp_out : prev_out;

      n_checks++;
      if (voice_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL %s ready cycle %0d: got %b expected %b", name, k, voice_ready, exp_ready);
      end
      n_checks++;
      if (write_audio_out !== exp_wr) begin
        n_fail++;
        $display("FAIL %s write cycle %0d: got %b expected %b", name, k, write_audio_out, exp_wr);
      end
      n_checks++;
      if (underrun !== exp_ur) begin
        n_fail++;
        $display("FAIL %s underrun cycle %0d: got %b expected %b", name, k, underrun, exp_ur);
      end
      n_checks++;
      if (clip !== exp_clip) begin
        n_fail++;
        $display("FAIL %s clip cycle %0d: got %b expected %b", name, k, clip, exp_clip);
      end
      n_checks++;
      if (left_out !== exp_lr) begin
        n_fail++;
        $display("FAIL %s left cycle %0d: got %h expected %h", name, k, left_out, exp_lr);
      end
      n_checks++;
      if (right_out !== exp_lr) begin
        n_fail++;
        $display("FAIL %s right cycle %0d: got %h expected %h", name, k, right_out, exp_lr);
      end

      if (write_audio_out === 1'b1) begin
        n_writes++;
        written = left_out;
      end
      if (underrun === 1'b1) n_underruns++;
    end
    prev_out = exp_out;
  endtask

  task automatic test_reset();
    resetn            = 1'b0;
    voice_active      = '1;
    voice_valid       = '1;
    voice_data        = {$urandom, $urandom, $urandom, $urandom};
    audio_out_allowed = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    #1;
    n_checks++;
    if ({voice_ready, write_audio_out, underrun, clip} !== '0) begin
      n_fail++;
      $display("FAIL reset strobes: got ready=%b wr=%b ur=%b clip=%b expected all 0",
               voice_ready, write_audio_out, underrun, clip);
    end
    n_checks++;
    if (left_out !== '0 || right_out !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h/%h expected 0/0", left_out, right_out);
    end
  endtask

  task automatic test_all_active();
    int w, u;
    logic [SW-1:0] wr;
    clear_frame();
    for (int j = 0; j < NV; j++) begin
      f_act[j] = 1'b1;
      f_dly[j] = 0;
    end
    f_smp[0] = 100; f_smp[1] = 200; f_smp[2] = -50; f_smp[3] = 7;
    run_frame("all_active", w, u, wr);
    n_checks++;
    if (w !== 1 || wr !== 32'd257) begin
      n_fail++;
      $display("FAIL all_active result: got %0d writes value %0d expected 1 write value 257", w, wr);
    end
  endtask

  task automatic test_inactive_skip();
    int w, u;
    logic [SW-1:0] wr;
    clear_frame();
    f_act[0] = 1'b1; f_smp[0] = 1000; f_dly[0] = 0;
    f_act[2] = 1'b1; f_smp[2] = 24;   f_dly[2] = 1;
    f_smp[1] = 555;  f_dly[1] = 0;
    f_smp[3] = -9;   f_dly[3] = 0;
    run_frame("inactive_skip", w, u, wr);
    n_checks++;
    if (w !== 1 || wr !== 32'd1024) begin
      n_fail++;
      $display("FAIL inactive_skip result: got %0d writes value %0d expected 1 write value 1024", w, wr);
    end
  endtask

  task automatic test_timeout();
    int w, u;
    logic [SW-1:0] wr;
    clear_frame();
    for (int j = 0; j < NV; j++) begin
      f_act[j] = 1'b1;
      f_dly[j] = 0;
    end
    f_smp[0] = 11; f_smp[1] = 22; f_smp[2] = 999; f_smp[3] = 33;
    f_dly[2] = -1;
    run_frame("timeout", w, u, wr);
    n_checks++;
    if (w !== 1 || u !== 1 || wr !== 32'd66) begin
      n_fail++;
      $display("FAIL timeout result: got %0d writes %0d underruns value %0d expected 1 1 66", w, u, wr);
    end
  endtask

  task automatic test_overflow();
    int w, u;
    logic [SW-1:0] wr;
    logic [SW-1:0] want;
`ifdef MIX_SATURATE_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'hFFFF_FFFC;
`endif
    clear_frame();
    for (int j = 0; j < NV; j++) begin
      f_act[j] = 1'b1;
      f_dly[j] = 0;
      f_smp[j] = 32'h7FFF_FFFF;
    end
    run_frame("overflow", w, u, wr);
    n_checks++;
    if (w !== 1 || wr !== want) begin
      n_fail++;
      $display("FAIL overflow result: got %0d writes value %h expected 1 write value %h", w, wr, want);
    end
  endtask

  task automatic test_backpressure();
    int w, u;
    logic [SW-1:0] wr;
    clear_frame();
    for (int j = 0; j < NV; j++) begin
      f_act[j] = 1'b1;
      f_dly[j] = j;
      f_smp[j] = $urandom_range(0, 5000) - 2500;
    end
    f_hold = 20;
    run_frame("backpressure", w, u, wr);
    n_checks++;
    if (w !== 1 || wr !== prev_out) begin
      n_fail++;
      $display("FAIL backpressure result: got %0d writes value %h expected 1 write value %h", w, wr, prev_out);
    end
  endtask

  task automatic test_active_drop();
    int w, u;
    logic [SW-1:0] wr;
    clear_frame();
    for (int j = 0; j < NV; j++) begin
      f_act[j] = 1'b1;
      f_dly[j] = 0;
    end
    f_smp[0] = 5; f_smp[1] = 1234; f_smp[2] = 6; f_smp[3] = 7;
    f_dly[1]  = -1;
    f_drop[1] = 5;
    run_frame("active_drop", w, u, wr);
    n_checks++;
    if (w !== 1 || u !== 0 || wr !== 32'd18) begin
      n_fail++;
      $display("FAIL active_drop result: got %0d writes %0d underruns value %0d expected 1 0 18", w, u, wr);
    end
  endtask

  task automatic test_mid_frame_reset();
    int w, u;
    logic [SW-1:0] wr;
    clear_frame();
    for (int j = 0; j < NV; j++) begin
      f_act[j] = 1'b1;
      f_dly[j] = 0;
      f_smp[j] = j + 1;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLOCK_50);
      voice_active      = '1;
      voice_valid       = '1;
      audio_out_allowed = 1'b1;
      for (int j = 0; j < NV; j++) voice_data[j*SW +: SW] = f_smp[j];
    end
    @(negedge CLOCK_50);
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({voice_ready, write_audio_out, underrun, clip} !== '0 || left_out !== '0 || right_out !== '0) begin
      n_fail++;
      $display("FAIL mid_reset outputs: got ready=%b wr=%b ur=%b clip=%b l=%h r=%h expected all 0",
               voice_ready, write_audio_out, underrun, clip, left_out, right_out);
    end
    prev_out = '0;
    for (int j = 0; j < NV; j++) f_smp[j] = j + 5;
    run_frame("after_reset", w, u, wr);
    n_checks++;
    if (w !== 1 || wr !== 32'd26) begin
      n_fail++;
      $display("FAIL after_reset result: got %0d writes value %0d expected 1 write value 26", w, wr);
    end
  endtask

  task automatic test_random();
    int w, u;
    logic [SW-1:0] wr;
    for (int f = 0; f < 10; f++) begin
      clear_frame();
      for (int j = 0; j < NV; j++) begin
        f_act[j] = 1'($urandom_range(0, 1)) | 1'($urandom_range(0, 1));
        f_smp[j] = $urandom;
        if ($urandom_range(0, 7) == 0) begin
          f_dly[j]  = -1;
          f_drop[j] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, TO - 1)) : -1;
        end else begin
          f_dly[j] = $urandom_range(0, 6);
        end
      end
      f_hold = $urandom_range(0, 3);
      run_frame("random", w, u, wr);
      n_checks++;
      if (w !== 1 || wr !== prev_out) begin
        n_fail++;
        $display("FAIL random frame %0d: got %0d writes value %h expected 1 write value %h", f, w, wr, prev_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w, u;
    logic [SW-1:0] wr;
    for (int f = 0; f < 3; f++) begin
      clear_frame();
      for (int j = 0; j < NV; j++) begin
        f_act[j] = 1'b1;
        f_dly[j] = 0;
        f_smp[j] = $urandom_range(0, 100000) - 50000;
      end
      run_frame("back_to_back", w, u, wr);
      n_checks++;
      if (w !== 1 || wr !== prev_out) begin
        n_fail++;
        $display("FAIL back_to_back frame %0d: got %0d writes value %h expected 1 write value %h", f, w, wr, prev_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_active();
    test_inactive_skip();
    test_timeout();
    test_overflow();
    test_backpressure();
    test_active_drop();
    test_mid_frame_reset();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
